// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular-exponentiation unit: FSM states and default width.
package rsa_pkg;

  localparam int unsigned RsaWidthDefault = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMul,
    StStep,
    StDone
  } rsa_state_e;

endpackage

// File: rtl/rsa_modmul.sv
// Interleaved MSB-first modular multiplier: one bit of a per run cycle, WIDTH cycles per product.
// start (sync) zeroes the accumulator; a, b and m must stay stable while run is high.
module rsa_modmul #(
  parameter int unsigned WIDTH = rsa_pkg::RsaWidthDefault
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start,
  input  logic             run,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] product,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH+1:0] p_q, p_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [CntW-1:0]  idx;
  logic             a_bit;
  logic [WIDTH+1:0] mm, acc, acc1, acc2;

  always_comb begin
    idx   = CntW'(WIDTH - 1) - cnt_q;
    a_bit = a[idx];
    mm    = {2'b00, m};
    // P < M keeps 2P + B below 3M, so WIDTH+2 bits never overflow.
    acc   = (p_q << 1) + (a_bit ? {2'b00, b} : '0);
    acc1  = (acc >= mm) ? acc - mm : acc;
    acc2  = (acc1 >= mm) ? acc1 - mm : acc1;
  end

  always_comb begin
    p_d   = p_q;
    cnt_d = cnt_q;
    if (start) begin
      p_d   = '0;
      cnt_d = '0;
    end else if (run) begin
      p_d   = acc2;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      p_q   <= '0;
      cnt_q <= '0;
    end else if (ena) begin
      p_q   <= p_d;
      cnt_q <= cnt_d;
    end
  end

  assign product = p_q[WIDTH-1:0];
  assign done    = run && (cnt_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/rsa_modexp.sv
// Right-to-left binary modular exponentiation built on two parallel rsa_modmul units.
// Optional RSA_EXP_EARLY_EXIT_EN: finish as soon as the remaining exponent is zero.
module rsa_modexp #(
  parameter int unsigned WIDTH = rsa_pkg::RsaWidthDefault
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             en_rsa,
  input  logic             clear_rsa,
  input  logic [WIDTH-1:0] plain_text,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] cipher_text,
  output logic             eoc_rsa,
  output logic             busy
);

  import rsa_pkg::*;

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  rsa_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [CntW-1:0]  bitcnt_q, bitcnt_d, bitcnt_inc;
  logic [WIDTH-1:0] cipher_q, cipher_d;

  logic             load_bad, last_bit;
  logic             mul_start, mul_run, done_r, done_b, mul_done;
  logic [WIDTH-1:0] prod_r, prod_b;

  assign load_bad   = (modulus < WIDTH'(2)) || (plain_text >= modulus);
  assign bitcnt_inc = bitcnt_q + 1'b1;

`ifdef RSA_EXP_EARLY_EXIT_EN
  assign last_bit = (bitcnt_inc == CntW'(WIDTH)) || (exp_q[WIDTH-1:1] == '0);
`else
  assign last_bit = (bitcnt_inc == CntW'(WIDTH));
`endif

  assign mul_start = (state_d == StMul) && (state_q != StMul);
  assign mul_run   = (state_q == StMul);
  assign mul_done  = done_r && done_b;

  rsa_modmul #(.WIDTH(WIDTH)) u_mul_result (
    .clk     (clk),
    .rstb    (rstb),
    .ena     (ena),
    .start   (mul_start),
    .run     (mul_run),
    .a       (result_q),
    .b       (base_q),
    .m       (mod_q),
    .product (prod_r),
    .done    (done_r)
  );

  rsa_modmul #(.WIDTH(WIDTH)) u_mul_square (
    .clk     (clk),
    .rstb    (rstb),
    .ena     (ena),
    .start   (mul_start),
    .run     (mul_run),
    .a       (base_q),
    .b       (base_q),
    .m       (mod_q),
    .product (prod_b),
    .done    (done_b)
  );

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= StIdle;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Clear and abort both dominate every state transition.
  always_comb begin
    state_d = state_q;
    if (!clear_rsa || !en_rsa) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StLoad;
        StLoad:  state_d = load_bad ? StDone : StMul;
        StMul:   if (mul_done) state_d = StStep;
        StStep:  state_d = last_bit ? StDone : StMul;
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    eoc_rsa = (state_q == StDone);
    busy    = (state_q == StLoad) || (state_q == StMul) || (state_q == StStep);
  end

  always_comb begin
    result_d = result_q;
    base_d   = base_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    bitcnt_d = bitcnt_q;
    unique case (state_q)
      StLoad: begin
        result_d = WIDTH'(1);
        base_d   = plain_text;
        exp_d    = exponent;
        mod_d    = modulus;
        bitcnt_d = '0;
      end
      StStep: begin
        result_d = exp_q[0] ? prod_r : result_q;
        base_d   = prod_b;
        exp_d    = exp_q >> 1;
        bitcnt_d = bitcnt_inc;
      end
      default: ;
    endcase
  end

  // The result is published only on entry to DONE, so an abort leaves the last value visible.
  always_comb begin
    cipher_d = cipher_q;
    if (!clear_rsa) begin
      cipher_d = '0;
    end else if ((state_d == StDone) && (state_q != StDone)) begin
      cipher_d = (state_q == StLoad) ? '0 : result_d;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      result_q <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      mod_q    <= '0;
      bitcnt_q <= '0;
      cipher_q <= '0;
    end else if (ena) begin
      result_q <= result_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      mod_q    <= mod_d;
      bitcnt_q <= bitcnt_d;
      cipher_q <= cipher_d;
    end
  end

  assign cipher_text = cipher_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// Scoreboard bench for rsa_modexp: stimulus queues expected cipher/latency, a monitor checks on eoc.
module tb_rsa_modexp;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rstb = 1'b0;
  logic         ena = 1'b1;
  logic         en_rsa = 1'b0;
  logic         clear_rsa = 1'b1;
  logic [W-1:0] plain_text = '0;
  logic [W-1:0] exponent = '0;
  logic [W-1:0] modulus = '0;
  logic [W-1:0] cipher_text;
  logic         eoc_rsa;
  logic         busy;

  rsa_modexp #(.WIDTH(W)) dut (
    .clk         (clk),
    .rstb        (rstb),
    .ena         (ena),
    .en_rsa      (en_rsa),
    .clear_rsa   (clear_rsa),
    .plain_text  (plain_text),
    .exponent    (exponent),
    .modulus     (modulus),
    .cipher_text (cipher_text),
    .eoc_rsa     (eoc_rsa),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] cipher;
    int           lat;
    int           load_wall;
    string        name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   wall = 0;
  logic eoc_prev = 1'b0;

  always @(posedge clk) wall = wall + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] e);
    int k;
    k = 1;
`ifdef RSA_EXP_EARLY_EXIT_EN
    for (int i = 0; i < int'(W); i++) if (e[i]) k = i + 1;
`else
    k = W;
`endif
    return 1 + k * (W + 1);
  endfunction

  // Monitor: compares each DONE entry against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t item;
    if (rstb && eoc_rsa && !eoc_prev) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_eoc: got cipher %0d, expected no completion", cipher_text);
      end else begin
        item = sb.pop_front();
        check({item.name, "_cipher"}, 32'(cipher_text), 32'(item.cipher));
        check({item.name, "_latency"}, wall - item.load_wall, item.lat);
      end
    end
    eoc_prev = eoc_rsa;
  end

  task automatic start_op(input logic [W-1:0] p, input logic [W-1:0] e, input logic [W-1:0] m);
    @(negedge clk);
    plain_text = p;
    exponent   = e;
    modulus    = m;
    clear_rsa  = 1'b1;
    en_rsa     = 1'b1;
  endtask

  task automatic run_vec(input string name, input logic [W-1:0] p, input logic [W-1:0] e,
                         input logic [W-1:0] m, input logic [W-1:0] expc, input bit gap,
                         input bit clr_end);
    exp_t item;
    int   t;
    start_op(p, e, m);
    item.cipher    = expc;
    item.lat       = ((m < 2) || (p >= m)) ? 1 : exp_lat(e);
    item.lat       = gap ? item.lat + 10 : item.lat;
    item.load_wall = wall + 1;
    item.name      = name;
    sb.push_back(item);
    @(negedge clk);
    check({name, "_busy_load"}, 32'(busy), 32'd1);
    if (gap) begin
      repeat (19) @(negedge clk);
      ena = 1'b0;
      repeat (10) @(negedge clk);
      ena = 1'b1;
    end
    t = 0;
    while (!eoc_rsa && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!eoc_rsa) check({name, "_timeout"}, 32'(eoc_rsa), 32'd1);
    repeat (3) @(negedge clk);
    check({name, "_done_hold"}, 32'(eoc_rsa), 32'd1);
    check({name, "_done_cipher"}, 32'(cipher_text), 32'(expc));
    en_rsa = 1'b0;
    if (clr_end) clear_rsa = 1'b0;
    @(negedge clk);
    clear_rsa = 1'b1;
    check({name, "_eoc_after_release"}, 32'(eoc_rsa), 32'd0);
    check({name, "_cipher_after_release"}, 32'(cipher_text), clr_end ? 32'd0 : 32'(expc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    #12;
    check("reset_cipher", 32'(cipher_text), 32'd0);
    check("reset_eoc", 32'(eoc_rsa), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    run_vec("rsa_88_e7", 8'd88, 8'd7, 8'd187, 8'd11, 1'b0, 1'b0);
    run_vec("rsa_11_e23", 8'd11, 8'd23, 8'd187, 8'd88, 1'b0, 1'b0);
    run_vec("exp_zero", 8'd88, 8'd0, 8'd187, 8'd1, 1'b0, 1'b0);
    run_vec("plain_ge_mod", 8'd200, 8'd7, 8'd187, 8'd0, 1'b0, 1'b0);
    run_vec("mod_one", 8'd0, 8'd3, 8'd1, 8'd0, 1'b0, 1'b0);
    run_vec("small_5_e2", 8'd5, 8'd2, 8'd13, 8'd12, 1'b0, 1'b0);
    run_vec("mod255_sq", 8'd254, 8'd2, 8'd255, 8'd1, 1'b0, 1'b0);
    run_vec("ena_gap", 8'd88, 8'd7, 8'd187, 8'd11, 1'b1, 1'b0);

    // Abort mid-computation: previous result (11) must survive, then clear zeroes it.
    start_op(8'd11, 8'd23, 8'd187);
    repeat (30) @(negedge clk);
    en_rsa = 1'b0;
    @(negedge clk);
    check("abort_eoc", 32'(eoc_rsa), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cipher_kept", 32'(cipher_text), 32'd11);
    clear_rsa = 1'b0;
    @(negedge clk);
    clear_rsa = 1'b1;
    check("clear_cipher", 32'(cipher_text), 32'd0);

    run_vec("clear_wins", 8'd11, 8'd23, 8'd187, 8'd88, 1'b0, 1'b1);

    // Asynchronous reset mid-MUL, checked before the next clock edge.
    run_vec("pre_reset", 8'd5, 8'd2, 8'd13, 8'd12, 1'b0, 1'b0);
    start_op(8'd88, 8'd7, 8'd187);
    repeat (20) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 rstb = 1'b0;
    #1;
    check("async_rst_cipher", 32'(cipher_text), 32'd0);
    check("async_rst_eoc", 32'(eoc_rsa), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    en_rsa = 1'b0;
    @(negedge clk);
    rstb = 1'b1;

    run_vec("post_reset", 8'd88, 8'd7, 8'd187, 8'd11, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rsa_modexp.md
RSA_MODEXP -- requirements
Module: rsa_modexp

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand/modulus/exponent width in bits (WIDTH >= 4).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rstb  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port ena  input  1  global enable; when 0 every register holds.
REQ-005 SHALL have port en_rsa  input  1  unit enable from the RSA control FSM.
REQ-006 SHALL have port clear_rsa  input  1  active-low synchronous clear (0 = hold cleared, 1 = released).
REQ-007 SHALL have port plain_text  input  WIDTH  base operand, sampled in LOAD.
REQ-008 SHALL have port exponent  input  WIDTH  exponent, sampled in LOAD.
REQ-009 SHALL have port modulus  input  WIDTH  modulus, sampled in LOAD.
REQ-010 SHALL have port cipher_text  output  WIDTH  result (plain_text^exponent mod modulus).
REQ-011 SHALL have port eoc_rsa  output  1  end of conversion, level.
REQ-012 SHALL have port busy  output  1  high in LOAD, MUL and STEP.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, MUL, STEP, DONE; eoc_rsa = (state==DONE), Moore.
REQ-014 IDLE -> LOAD SHALL occur when en_rsa=1 and clear_rsa=1; LOAD SHALL last one cycle and latch operands, set result=1, base=plain_text, bit counter=0.
REQ-015 In LOAD, if modulus < 2 or plain_text >= modulus, SHALL go directly to DONE with cipher_text=0.
REQ-016 MUL SHALL run two rsa_modmul instances in parallel (result*base and base*base), each WIDTH cycles, then go to STEP.
REQ-017 STEP (one cycle) SHALL update result with the product only if the current exponent LSB is 1, always update base with the square, shift the exponent right, and increment the bit counter.
REQ-018 After STEP, SHALL go to DONE when the bit counter reaches WIDTH, else to MUL.
REQ-019 Fixed latency: DONE SHALL be entered exactly 1 + WIDTH*(WIDTH+1) enabled cycles after LOAD is entered (73 for WIDTH=8).
REQ-020 cipher_text SHALL be loaded on DONE entry only and held until clear; exponent 0 SHALL yield 1.
REQ-021 DONE SHALL hold until en_rsa=0 or clear_rsa=0.
REQ-022 en_rsa=0 in any state SHALL force IDLE next cycle (abort), with cipher_text retained.
REQ-023 clear_rsa=0 SHALL force IDLE and zero cipher_text; if en_rsa=0 and clear_rsa=0 occur together, the clear wins.
REQ-024 ena=0 SHALL freeze FSM, counters and sub-module state; latency counts only cycles with ena=1.
REQ-025 Multiplier arithmetic SHALL be interleaved MSB-first: P = 2P + a_i*B, then up to two conditional subtractions of M, with a WIDTH+2-bit internal accumulator, no overflow.

Reset
REQ-026 rstb=0 SHALL asynchronously force state=IDLE, cipher_text=0, eoc_rsa=0, busy=0, and all internal registers to 0.

Configuration
REQ-027 With RSA_EXP_EARLY_EXIT_EN defined, STEP SHALL go to DONE as soon as the shifted exponent is 0 (latency 1 + k*(WIDTH+1), k = index of MSB set + 1; exponent 0 gives k=1); without the macro, latency SHALL be fixed per REQ-019.

Structure
REQ-028 Shared package rsa_pkg SHALL hold the FSM state typedef and the default WIDTH constant.
REQ-029 SHALL instantiate sub-module rsa_modmul (start, a, b, m -> product, done) twice.

Verification
REQ-030 WIDTH=8, M=187, e=7, plain=88 -> cipher_text=11, eoc_rsa high 73 cycles after LOAD (28 with RSA_EXP_EARLY_EXIT_EN).
REQ-031 M=187, e=23, plain=11 -> cipher_text=88; e=0 -> cipher_text=1.
REQ-032 plain=200, M=187 -> DONE one cycle after LOAD, cipher_text=0; M=1 -> same.
REQ-033 en_rsa dropped at cycle 30 -> IDLE next cycle, eoc_rsa=0, cipher_text unchanged; later clear_rsa=0 -> cipher_text=0.
REQ-034 ena low for 10 cycles mid-MUL -> result unchanged, eoc_rsa delayed by exactly 10 cycles.
REQ-035 rstb asserted mid-MUL -> outputs 0 immediately, without waiting for a clock edge.
